// File: rtl/cpu_step_display.sv
// Board front end for the multi-cycle CPU: push-button debounce into a single-step CPU clock
// plus a 4-digit multiplexed 7-segment view of CPU buses. Optional macro CPU_STEP_DP_EN lights dp on digit 0 while cpu_clk is high.
module cpu_step_display #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_CYCLES     = 100000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        step_btn,
    input  logic [1:0]  sel,
    input  logic [31:0] curPC,
    input  logic [31:0] nextPC,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic [31:0] result,
    input  logic [31:0] WriteData,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        cpu_clk,
    output logic        step_pulse,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    // state         | meaning
    // IDLE          | button released and stable, cpu_clk low
    // CHECK_PRESS   | s high, counting stable samples before accepting press
    // PRESSED       | button held and stable, cpu_clk high
    // CHECK_RELEASE | s low, counting stable samples before accepting release

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int SCAN_W = $clog2(SCAN_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        CHECK_PRESS   = 2'd1,
        PRESSED       = 2'd2,
        CHECK_RELEASE = 2'd3
    } db_state_t;

    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       sync_q;
    logic             s;
    logic             clk_nxt;
    logic             pulse_nxt;

    assign s = sync_q[1];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync_q     <= '0;
            state      <= IDLE;
            cnt        <= '0;
            cpu_clk    <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], step_btn};
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cpu_clk    <= clk_nxt;
            step_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (s) state_nxt = CHECK_PRESS;
            end
            CHECK_PRESS: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) state_nxt = CHECK_RELEASE;
            end
            CHECK_RELEASE: begin
                if (s) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // the stability counter restarts on any state change
        if (state_nxt != state) cnt_nxt = '0;
        clk_nxt = (state_nxt == PRESSED) || (state_nxt == CHECK_RELEASE);
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit, digit_nxt;
    logic [7:0]        left_b, right_b;
    logic [3:0]        nib;
    logic [3:0]        an_q;
    logic [6:0]        seg_q;
    logic              dp;
    logic              unused_bits;

    assign unused_bits = ^{curPC[31:8], nextPC[31:8], ReadData1[31:8],
                           ReadData2[31:8], result[31:8], WriteData[31:8]};

    always_comb begin
        left_b  = '0;
        right_b = '0;
        case (sel)
            2'b00: begin left_b = curPC[7:0];   right_b = nextPC[7:0];    end
            2'b01: begin left_b = {3'b000, rs}; right_b = ReadData1[7:0]; end
            2'b10: begin left_b = {3'b000, rt}; right_b = ReadData2[7:0]; end
            default: begin left_b = result[7:0]; right_b = WriteData[7:0]; end
        endcase
    end

    assign digit_nxt = digit + 2'd1;

    always_comb begin
        nib = '0;
        case (digit_nxt)
            2'd0: nib = right_b[3:0];
            2'd1: nib = right_b[7:4];
            2'd2: nib = left_b[3:0];
            default: nib = left_b[7:4];
        endcase
    end

    // digit index starts at 3 so the first wrap lands on digit 0
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            scan_cnt <= '0;
            digit    <= 2'd3;
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit    <= digit_nxt;
            an_q     <= ~(4'b0001 << digit_nxt);
            seg_q    <= hex7(nib);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

`ifdef CPU_STEP_DP_EN
    // digit only reaches 0 through a load, so digit==0 means digit 0 is shown
    assign dp = ~((digit == 2'd0) && cpu_clk);
`else
    assign dp = 1'b1;
`endif

    assign an  = an_q;
    assign seg = {dp, seg_q};

endmodule
